// File: rtl/bts_user_io_ctrl.sv
// Avalon-MM user-I/O controller: debounced buttons/switches, sticky edge capture with a
// maskable level irq, and static/blink LED drive. Optional macro: BTS_SW_EDGE_IRQ_EN.
module bts_user_io_ctrl #(
  parameter int unsigned NUM_PB          = 4,
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_LED         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLINK_DIV       = 12500000
) (
  input  logic               clkin_50,
  input  logic               reset,
  input  logic [NUM_PB-1:0]  user_pbin,
  input  logic [NUM_SW-1:0]  user_dipsw,
  output logic [NUM_LED-1:0] user_led,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq
);

  localparam int unsigned NumIn = NUM_PB + NUM_SW;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BlW   = $clog2(BLINK_DIV);
  // Button bits: raw inputs are active low, so their synchronizers idle at 1.
  localparam logic [NumIn-1:0] PbMask = {{NUM_SW{1'b0}}, {NUM_PB{1'b1}}};
`ifdef BTS_SW_EDGE_IRQ_EN
  localparam logic [NumIn-1:0] CapMask = '1;
`else
  localparam logic [NumIn-1:0] CapMask = PbMask;
`endif

  logic [NumIn-1:0]   sync1_q, sync2_q, in_hi;
  logic [NumIn-1:0]   deb_q, deb_d, flip;
  logic [DbW-1:0]     cnt_q [NumIn];
  logic [DbW-1:0]     cnt_d [NumIn];
  logic [NumIn-1:0]   cap_q, cap_d, cap_set, cap_clr;
  logic [NumIn-1:0]   mask_q, mask_d;
  logic [NUM_LED-1:0] val_q, val_d, mode_q, mode_d, led_q, led_d;
  logic [BlW-1:0]     blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  assign in_hi = sync2_q ^ PbMask;

  always_comb begin
    flip = '0;
    for (int i = 0; i < NumIn; i++) begin
      cnt_d[i] = '0;
      if (in_hi[i] != deb_q[i]) begin
        if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    deb_d = deb_q ^ flip;
  end

  // Buttons capture press (0->1) only; switches capture either direction.
  always_comb begin
    cap_set = flip & (deb_d | ~PbMask) & CapMask;
    cap_clr = (avs_write && avs_address == 3'd2) ? avs_writedata[NumIn-1:0] : '0;
    cap_d   = ((cap_q & ~cap_clr) | cap_set) & CapMask;
    mask_d  = mask_q;
    val_d   = val_q;
    mode_d  = mode_q;
    if (avs_write) begin
      case (avs_address)
        3'd3:    mask_d = avs_writedata[NumIn-1:0] & CapMask;
        3'd4:    val_d  = avs_writedata[NUM_LED-1:0];
        3'd5:    mode_d = avs_writedata[NUM_LED-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        3'd0:    rdata_d = 32'(deb_q[NUM_PB-1:0]);
        3'd1:    rdata_d = 32'(deb_q[NumIn-1:NUM_PB]);
        3'd2:    rdata_d = 32'(cap_q);
        3'd3:    rdata_d = 32'(mask_q);
        3'd4:    rdata_d = 32'(val_q);
        3'd5:    rdata_d = 32'(mode_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    if (blink_cnt_q == BlW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    led_d = ~(val_d & (~mode_d | {NUM_LED{phase_q}}));
    irq_d = |(cap_q & mask_q);
  end

  always_ff @(posedge clkin_50 or posedge reset) begin
    if (reset) begin
      sync1_q     <= PbMask;
      sync2_q     <= PbMask;
      deb_q       <= '0;
      for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
      cap_q       <= '0;
      mask_q      <= '0;
      val_q       <= '0;
      mode_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '1;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sync1_q     <= {user_dipsw, user_pbin};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      val_q       <= val_d;
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign user_led     = led_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_bts_user_io_ctrl.sv
// Randomized scoreboard bench for bts_user_io_ctrl against a behavioural model.
// Build with or without BTS_SW_EDGE_IRQ_EN; expectations follow the macro.
module tb_bts_user_io_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BDIV = 8;
`ifdef BTS_SW_EDGE_IRQ_EN
  localparam logic [7:0] CAP = 8'hFF;
`else
  localparam logic [7:0] CAP = 8'h0F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  user_pbin = 4'hF;
  logic [3:0]  user_dipsw = 4'h0;
  logic [3:0]  user_led;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic        irq;

  always #5 clk = ~clk;

  bts_user_io_ctrl #(
    .NUM_PB(4), .NUM_SW(4), .NUM_LED(4), .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BDIV)
  ) dut (
    .clkin_50(clk), .reset(rst), .user_pbin(user_pbin), .user_dipsw(user_dipsw),
    .user_led(user_led), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pressed-high stimulus state; pins are derived from these at drive time.
  logic [3:0] pb_hi = 4'h0;
  logic [3:0] sw = 4'h0;

  // Behavioural model state.
  logic [7:0]  m_deb, m_edge, m_mask;
  logic [3:0]  m_val, m_mode;
  int          m_cyc;
  logic [7:0]  rawq[$];
  logic [7:0]  shist[$];
  logic [31:0] rd_exp_q[$];
  logic [4:0]  out_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_deb = '0; m_edge = '0; m_mask = '0; m_val = '0; m_mode = '0; m_cyc = 0;
    rawq.delete();
    shist.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'h0, m_deb[3:0]};
      3'd1:    return {28'h0, m_deb[7:4]};
      3'd2:    return {24'h0, m_edge};
      3'd3:    return {24'h0, m_mask};
      3'd4:    return {28'h0, m_val};
      3'd5:    return {28'h0, m_mode};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the model: an input is accepted once the synchronized sample has
  // disagreed with the accepted state for DEB consecutive edges.
  task automatic model_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [7:0] s, flip, deb_new, set, clr;
    logic [3:0] led_e;
    logic       irq_e, ph;
    irq_e = |(m_edge & m_mask);
    ph    = ((m_cyc / BDIV) % 2) != 0;
    s     = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 8'h00;
    rawq.push_back({sw, pb_hi});
    if (rawq.size() > 2) void'(rawq.pop_front());
    shist.push_back(s);
    if (shist.size() > DEB) void'(shist.pop_front());
    flip = '0;
    if (shist.size() == DEB) begin
      for (int b = 0; b < 8; b++) begin
        bit steady;
        steady = 1'b1;
        foreach (shist[k]) if (shist[k][b] == m_deb[b]) steady = 1'b0;
        flip[b] = steady;
      end
    end
    deb_new = m_deb ^ flip;
    set = '0;
    for (int b = 0; b < 4; b++) set[b] = !m_deb[b] && deb_new[b];
    for (int b = 4; b < 8; b++) set[b] = m_deb[b] != deb_new[b];
    set = set & CAP;
    clr = (wr && a == 3'd2) ? wd[7:0] : 8'h00;
    m_edge = (m_edge & ~clr) | set;
    if (wr) begin
      case (a)
        3'd3:    m_mask = wd[7:0] & CAP;
        3'd4:    m_val  = wd[3:0];
        3'd5:    m_mode = wd[3:0];
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) led_e[i] = !(m_val[i] && (m_mode[i] ? ph : 1'b1));
    m_deb = deb_new;
    m_cyc++;
    out_exp_q.push_back({irq_e, led_e});
  endtask

  task automatic tick(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd);
    @(negedge clk);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    user_pbin = ~pb_hi; user_dipsw = sw;
    if (rd) rd_exp_q.push_back(model_read(a));
    @(posedge clk);
    model_edge(wr, a, wd);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    avs_read = 1'b0;
    avs_write = 1'b0;
    rd_exp_q.delete();
    out_exp_q.delete();
    #1;
    check("reset_user_led", {28'h0, user_led}, 32'hF);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: reads return one edge after the strobe; irq/led are checked every cycle.
  initial begin : monitor
    logic       pend;
    logic [4:0] e;
    forever begin
      @(posedge clk);
      pend = avs_read && !rst;
      @(negedge clk);
      if (!rst) begin
        if (pend) begin
          if (rd_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_queue: got a read with no expected value at %0t", $time);
          end else begin
            check("readdata", avs_readdata, rd_exp_q.pop_front());
          end
        end
        if (out_exp_q.size() > 0) begin
          e = out_exp_q.pop_front();
          check("irq", {31'h0, irq}, {31'h0, e[4]});
          check("user_led", {28'h0, user_led}, {28'h0, e[3:0]});
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    do_reset();
    for (int a = 0; a < 8; a++) tick(1'b1, 1'b0, 3'(a), 32'h0);

    // Press button 1 for 10 cycles, then enable its interrupt.
    pb_hi = 4'b0010;
    repeat (10) tick(1'b1, 1'b0, 3'd0, 32'h0);
    pb_hi = 4'b0000;
    repeat (4) tick(1'b1, 1'b0, 3'd2, 32'h0);
    tick(1'b0, 1'b1, 3'd3, 32'h2);
    repeat (6) tick(1'b1, 1'b0, 3'd0, 32'h0);

    // Short glitch on button 0 must be rejected.
    pb_hi = 4'b0001;
    repeat (3) tick(1'b1, 1'b0, 3'd0, 32'h0);
    pb_hi = 4'b0000;
    repeat (8) tick(1'b1, 1'b0, 3'd2, 32'h0);

    // New press lands on the same edge as a W1C write: set wins.
    pb_hi = 4'b0010;
    repeat (5) tick(1'b1, 1'b0, 3'd0, 32'h0);
    tick(1'b0, 1'b1, 3'd2, 32'h2);
    repeat (2) tick(1'b1, 1'b0, 3'd2, 32'h0);
    tick(1'b0, 1'b1, 3'd2, 32'h2);
    repeat (3) tick(1'b1, 1'b0, 3'd2, 32'h0);
    pb_hi = 4'b0000;
    repeat (8) tick(1'b0, 1'b0, 3'd0, 32'h0);

    // Static LED 0, blinking LED 2.
    tick(1'b0, 1'b1, 3'd4, 32'h5);
    tick(1'b0, 1'b1, 3'd5, 32'h4);
    repeat (40) tick(1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'h0);

    // Switch 2 with its mask bit set.
    tick(1'b0, 1'b1, 3'd3, 32'h40);
    sw = 4'b0100;
    repeat (10) tick(1'b1, 1'b0, 3'd2, 32'h0);
    tick(1'b1, 1'b0, 3'd1, 32'h0);
    tick(1'b1, 1'b0, 3'd3, 32'h0);

    // Randomized traffic with resets mid-run (inputs possibly held across reset).
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 250; n++) begin
        logic       rd, wr;
        logic [2:0] a;
        if ($urandom_range(0, 7) == 0) begin
          int b;
          b = $urandom_range(0, 7);
          if (b < 4) pb_hi[b] = ~pb_hi[b];
          else sw[b-4] = ~sw[b-4];
        end
        rd = $urandom_range(0, 2) != 0;
        wr = $urandom_range(0, 3) == 0;
        a  = 3'($urandom_range(0, 7));
        tick(rd, wr, a, $urandom);
      end
      do_reset();
      for (int a = 0; a < 8; a++) tick(1'b1, 1'b0, 3'(a), 32'h0);
    end

    tick(1'b0, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    if (rd_exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_drain: %0d reads never returned, expected 0", rd_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bts_user_io_ctrl.md
Name: bts_user_io_ctrl

Overview:
Parametrised user-I/O controller for the board test system. It replaces the plain LED, DIP-switch and push-button PIOs with a single Avalon-MM slave that provides:
- debounced push-button and DIP-switch inputs,
- sticky press-edge capture with a maskable interrupt,
- per-LED static or blink drive.

It sits between the board pins and the system interconnect. Channel counts and timing are set by parameters.

Parameters:
- NUM_PB, 4, push-button count (1..16)
- NUM_SW, 4, DIP-switch count (1..16)
- NUM_LED, 4, LED count (1..16)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept an input change (>=2)
- BLINK_DIV, 12500000, clock cycles per blink half-period (>=2)

Ports:
- clkin_50, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- user_pbin, input, NUM_PB, raw push buttons, active low
- user_dipsw, input, NUM_SW, raw DIP switches, 1 = on
- user_led, output, NUM_LED, LED drive, active low
- avs_address, input, 3, word address
- avs_read, input, 1, read strobe
- avs_write, input, 1, write strobe
- avs_writedata, input, 32, write data
- avs_readdata, output, 32, read data, valid one cycle after avs_read
- irq, output, 1, level interrupt, active high

Behaviour:
- Interface: one clock domain (clkin_50). Reset is asynchronous and active-high on port reset.
- Register map (unused bits read 0, writes to read-only registers ignored):
  - 0 PB_STATE (RO): debounced button state, 1 = pressed.
  - 1 SW_STATE (RO): debounced switch state.
  - 2 EDGE_CAP (RW1C): bits [NUM_PB-1:0] hold press edges; bits [NUM_PB+NUM_SW-1:NUM_PB] are described under Optional Feature.
  - 3 IRQ_MASK (RW): width NUM_PB+NUM_SW.
  - 4 LED_VALUE (RW): 1 = LED on.
  - 5 LED_MODE (RW): per LED, 0 = static, 1 = blink.
  - 6, 7: read 0.
- Input path per bit:
  - 2-FF synchronizer. Push buttons are inverted to pressed-high before the debouncer.
  - Per-bit counter. It clears whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - Net latency from a raw edge to the debounced flip is DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced state.
- Edge capture:
  - A debounced button 0->1 transition sets its EDGE_CAP bit; the bit stays set until software clears it.
  - A write of 1 to EDGE_CAP clears the bit; writing 0 has no effect.
  - If a clear and a new edge hit the same bit in the same cycle, set wins.
- irq is registered: irq <= |(EDGE_CAP & IRQ_MASK). It asserts one cycle after the enabling condition and deasserts one cycle after the clear or unmask.
- Blink:
  - Free-running counter counts 0..BLINK_DIV-1. At wrap it toggles blink_phase, giving a period of 2*BLINK_DIV cycles.
  - Counter and phase are never reset by register writes.
- LED drive, registered, one cycle after a write:
  - user_led[i] = ~(LED_VALUE[i] & (LED_MODE[i] ? blink_phase : 1)).
- Read data is registered. avs_readdata holds its last value when avs_read is low. Simultaneous read and write to the same address returns the pre-write value.
- Reset values:
  - user_led all 1 (off).
  - avs_readdata 0, irq 0, all registers 0.
  - Debounced states 0.
  - Synchronizer FFs at the inactive level: 1 for user_pbin, 0 for user_dipsw.
  - Counters 0, blink_phase 0.
- Reset mid-debounce discards the partial count. A button still held after reset produces an edge only after a full DEBOUNCE_CYCLES stable window.

Optional Feature:
- Macro: BTS_SW_EDGE_IRQ_EN.
- Defined:
  - Any debounced switch transition (0->1 or 1->0) sets EDGE_CAP[NUM_PB+j].
  - These bits are W1C and maskable like the button bits, and contribute to irq.
- Undefined:
  - Switch debouncers still run, so SW_STATE is valid.
  - EDGE_CAP switch bits and IRQ_MASK switch bits read 0, writes to them are ignored, and switches never raise irq.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, BLINK_DIV=8.
- Reset check: assert reset mid-run -> user_led=4'hF, irq=0, all registers read 0 at once, no clock required for outputs.
- Press user_pbin[1] low for 10 cycles -> PB_STATE=0x2 exactly 6 cycles after the edge; EDGE_CAP=0x2; with IRQ_MASK=0x2, irq=1 the next cycle.
- Pulse user_pbin[0] low for 3 cycles -> PB_STATE and EDGE_CAP remain 0.
- EDGE_CAP=0x2: write 0x2 to address 2 in the same cycle as a new debounced press on button 1 -> bit stays 1. Write 0x2 alone -> EDGE_CAP=0, irq=0 one cycle later.
- Write LED_VALUE=0x5, LED_MODE=0x4 -> user_led[0]=0 steady; user_led[2] toggles every 8 cycles; user_led[1]=user_led[3]=1.
- Toggle user_dipsw[2] 0->1 with IRQ_MASK=0x40 -> with BTS_SW_EDGE_IRQ_EN: EDGE_CAP=0x40 and irq=1; without it: EDGE_CAP=0, irq=0, and SW_STATE=0x4 in both builds.
